// File: rtl/tt_counter_pkg.sv
// Shared definitions for the programmable mode counter.
// Count-mode encodings used by the counter datapath.
package tt_counter_pkg;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_ONESHOT  = 2'b11;

endpackage

// File: rtl/tt_prescaler.sv
// Clock-enable prescaler: one tick every prescale+1 enabled cycles.
// clr restarts the divider from zero (used by counter load).
module tt_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pc_q;
  logic [PRESCALE_W-1:0] pc_d;

  assign tick = en && (pc_q == prescale);

  // next divider value; wraps naturally if prescale drops below pc
  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (tick) begin
      pc_d = '0;
    end else if (en) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // divider register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/tt_mode_counter.sv
// Programmable up/down/ping-pong/one-shot counter with prescaler,
// synchronous load, terminal-count pulse and compare match.
module tt_mode_counter
  import tt_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      modulo,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cmp_val,
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  tc,
  output logic                  match,
  output logic                  done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             oor;
  logic             at_top;
  logic             at_zero;

  tt_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  assign oor     = cnt_q > modulo;
  assign at_top  = cnt_q == modulo;
  assign at_zero = cnt_q == '0;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dir_q  <= 1'b1;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  // next state: load beats tick; out-of-range recovers without tc
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    tc_d   = 1'b0;
    done_d = done_q;
    if (load) begin
      cnt_d  = (load_val > modulo) ? modulo : load_val;
      dir_d  = (mode != MODE_DOWN);
      done_d = 1'b0;
    end else if (tick) begin
      unique case (mode)
        MODE_UP: begin
          dir_d = 1'b1;
          if (oor) begin
            cnt_d = '0;
          end else if (at_top) begin
            cnt_d = '0;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (oor) begin
            cnt_d = modulo;
          end else if (at_zero) begin
            cnt_d = modulo;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        MODE_PINGPONG: begin
          if (oor) begin
            cnt_d = '0;
            dir_d = 1'b1;
          end else if (modulo == '0) begin
            cnt_d = '0;
            dir_d = ~dir_q;
            tc_d  = 1'b1;
          end else if (dir_q && at_top) begin
            cnt_d = modulo - ONE;
            dir_d = 1'b0;
            tc_d  = 1'b1;
          end else if (!dir_q && at_zero) begin
            cnt_d = ONE;
            dir_d = 1'b1;
            tc_d  = 1'b1;
          end else if (dir_q) begin
            cnt_d = cnt_q + ONE;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        MODE_ONESHOT: begin
          dir_d = 1'b1;
          if (!done_q) begin
            if (oor) begin
              cnt_d = '0;
            end else if (at_top) begin
              tc_d   = 1'b1;
              done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
        end
      endcase
    end
  end

  // outputs; match decodes the registered count
  always_comb begin
    count = cnt_q;
    dir   = dir_q;
    tc    = tc_q;
    done  = done_q;
    match = (cnt_q == cmp_val);
  end

endmodule

// File: tb/tb_tt_mode_counter.sv
// Directed + random bench for tt_mode_counter.
// Reference model derives each mode from cycle arithmetic.
module tb_tt_mode_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] modulo;
  logic [1:0] mode;
  logic [7:0] prescale;
  logic [7:0] cmp_val;
  logic [7:0] count;
  logic       dir;
  logic       tc;
  logic       match;
  logic       done;

  int errors = 0;
  int checks = 0;

  int m_cnt, m_pc;
  bit m_dir, m_tc, m_done;

  always #5 clk = ~clk;

  tt_mode_counter #(
    .WIDTH      (8),
    .PRESCALE_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .modulo   (modulo),
    .mode     (mode),
    .prescale (prescale),
    .cmp_val  (cmp_val),
    .count    (count),
    .dir      (dir),
    .tc       (tc),
    .match    (match),
    .done     (done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock of the specification's rules, from the inputs now applied
  task automatic model_step();
    bit tk;
    int md, per, p, np;
    bit nd;
    md = int'(modulo);
    if (!rst_n) begin
      m_cnt = 0; m_dir = 1; m_tc = 0; m_done = 0; m_pc = 0;
      return;
    end
    tk = en && (m_pc == int'(prescale));
    m_tc = 0;
    if (load) begin
      m_pc = 0;
      m_cnt = (int'(load_val) < md) ? int'(load_val) : md;
      m_dir = (mode != 2'b01);
      m_done = 0;
      return;
    end
    if (en) m_pc = tk ? 0 : (m_pc + 1) % 256;
    if (!tk) return;
    case (mode)
      2'b00: begin
        m_dir = 1;
        if (m_cnt > md) m_cnt = 0;
        else begin
          m_tc = (m_cnt == md);
          m_cnt = (m_cnt + 1) % (md + 1);
        end
      end
      2'b01: begin
        m_dir = 0;
        if (m_cnt > md) m_cnt = md;
        else begin
          m_tc = (m_cnt == 0);
          m_cnt = (m_cnt + md) % (md + 1);
        end
      end
      2'b10: begin
        if (m_cnt > md) begin
          m_cnt = 0; m_dir = 1;
        end else if (md == 0) begin
          m_cnt = 0; m_tc = 1; m_dir = !m_dir;
        end else begin
          per = 2 * md;
          p = m_dir ? m_cnt : (per - m_cnt) % per;
          np = (p + 1) % per;
          m_cnt = (np <= md) ? np : per - np;
          nd = (np >= 1) && (np <= md);
          m_tc = (nd != m_dir);
          m_dir = nd;
        end
      end
      default: begin
        m_dir = 1;
        if (!m_done) begin
          if (m_cnt > md) m_cnt = 0;
          else if (m_cnt == md) begin
            m_tc = 1; m_done = 1;
          end else m_cnt = m_cnt + 1;
        end
      end
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("count", int'(count), m_cnt);
    chk("dir", int'(dir), int'(m_dir));
    chk("tc", int'(tc), int'(m_tc));
    chk("done", int'(done), int'(m_done));
    chk("match", int'(match), int'(m_cnt == int'(cmp_val)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_up [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int exp_pp [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int r;

    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
    modulo = 8'd5; mode = 2'b00; prescale = '0; cmp_val = '0;
    @(negedge clk);
    do_reset();
    cycle();
    chk("reset_match", int'(match), 1);
    chk("reset_count", int'(count), 0);

    // up, modulo 5, tick every cycle
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("up_seq", int'(count), exp_up[i]);
      chk("up_tc", int'(tc), int'(i == 5 || i == 5 + 6));
    end

    // prescale 2, pause mid-run
    do_reset();
    prescale = 8'd2; modulo = 8'd255;
    for (int i = 0; i < 8; i++) cycle();
    chk("pre_count", int'(count), 2);
    en = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("pause_hold", int'(count), 2);
    en = 1'b1;
    for (int i = 0; i < 9; i++) cycle();
    chk("resume_count", int'(count), 5);

    // ping-pong modulo 3
    do_reset();
    prescale = '0; modulo = 8'd3; mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("pp_seq", int'(count), exp_pp[i]);
    end

    // one-shot modulo 4, then reload
    do_reset();
    modulo = 8'd4; mode = 2'b11;
    for (int i = 0; i < 15; i++) cycle();
    chk("os_hold", int'(count), 4);
    chk("os_done", int'(done), 1);
    load = 1'b1; load_val = 8'd1;
    cycle();
    load = 1'b0;
    chk("os_reload_done", int'(done), 0);
    for (int i = 0; i < 2; i++) cycle();
    chk("os_resume", int'(count), 3);

    // clamped load while a tick is due, then modulo lowered in down mode
    mode = 2'b00; modulo = 8'd50; load_val = 8'd200; load = 1'b1;
    cycle();
    chk("clamp", int'(count), 50);
    load = 1'b0; mode = 2'b01; modulo = 8'd10;
    cycle();
    chk("oor_down", int'(count), 10);
    chk("oor_tc", int'(tc), 0);

    // compare match and mid-count reset
    do_reset();
    mode = 2'b00; modulo = 8'd7; cmp_val = 8'd3;
    for (int i = 0; i < 5; i++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("midreset_count", int'(count), 0);
    for (int i = 0; i < 4; i++) cycle();

    // random mix
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(99, 0));
      rst_n = (r >= 2);
      en = ($urandom_range(9, 0) < 8);
      load = ($urandom_range(19, 0) == 0);
      load_val = 8'($urandom_range(255, 0));
      if ($urandom_range(19, 0) == 0) mode = 2'($urandom_range(3, 0));
      if ($urandom_range(29, 0) == 0)
        modulo = ($urandom_range(1, 0) == 1) ?
                 8'($urandom_range(15, 1)) : 8'($urandom_range(60, 20));
      if ($urandom_range(19, 0) == 0) prescale = 8'($urandom_range(3, 0));
      cmp_val = 8'($urandom_range(15, 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_mode_counter.md
Name: tt_mode_counter

Overview:
- Parametrised, programmable counter for the TinyTapeout user project; successor to the free-running 4-bit counter.
- Adds configurable width, programmable modulo, four count modes, a clock-enable prescaler, synchronous load, terminal-count pulse and compare-match output.
- Sits behind ui_in/uio_in-driven configuration registers in tt_um top.
- Drives uo_out status pins.

Parameters:
- WIDTH, 8, counter width in bits (2..16).
- PRESCALE_W, 8, prescaler reload width in bits (1..16).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- en  in  1  count enable; low freezes prescaler and counter
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded on load
- modulo  in  WIDTH  terminal value; count range is 0..modulo
- mode  in  2  count mode: 00 up, 01 down, 10 ping-pong, 11 one-shot up
- prescale  in  PRESCALE_W  one tick every prescale+1 enabled cycles
- cmp_val  in  WIDTH  compare value
- count  out  WIDTH  current count, registered
- dir  out  1  current direction: 1 up, 0 down; registered
- tc  out  1  terminal-count pulse, one cycle, registered
- match  out  1  count == cmp_val, combinational from registered count
- done  out  1  one-shot complete, sticky, registered

Behaviour:
- Reset (rst_n low at clk edge) gives: count=0, dir=1, tc=0, done=0, prescaler count=0. match then follows count (1 if cmp_val==0).
- Priority: reset > load > tick.
- Load:
  - count <= min(load_val, modulo). Prescaler count <= 0. done <= 0. tc <= 0.
  - dir <= 0 if mode==01, else 1.
  - en is ignored in the load cycle.
- Prescaler:
  - Internal counter pc. When en=1: if pc==prescale, tick=1 and pc<=0; else pc<=pc+1.
  - When en=0: pc holds and there is no tick.
  - prescale=0 gives a tick on every enabled cycle.
  - If prescale is lowered below pc, pc counts up and wraps naturally at 2^PRESCALE_W. No special case.
- tc defaults to 0 on every cycle. It is 1 only in the cycle after a tick that wraps or reverses.
- Mode up (00):
  - count<modulo: count+1.
  - count==modulo: count<=0, tc.
- Mode down (01):
  - count>0: count-1.
  - count==0: count<=modulo, tc.
- Mode ping-pong (10):
  - dir=1 and count==modulo: dir<=0, count<=modulo-1, tc.
  - dir=0 and count==0: dir<=1, count<=1, tc.
  - Otherwise step in dir.
  - modulo==0: count stays 0 and tc fires on every tick.
  - modulo==1: count alternates 0,1.
- Mode one-shot (11):
  - Counts up while done=0.
  - count==modulo on a tick: tc, done<=1, count holds.
  - While done=1, ticks are ignored until load or reset.
- modulo==0 in up, down or one-shot: count stays 0 and every tick asserts tc (one-shot sets done on the first tick).
- Out-of-range case (count>modulo at a tick, e.g. modulo lowered at runtime):
  - Up, one-shot and ping-pong: count<=0, dir<=1.
  - Down: count<=modulo.
  - tc is not asserted.
- Mode change mid-run:
  - Takes effect at the next tick. count is retained.
  - Entering mode 01 forces dir<=0 at that tick. Entering 00 or 11 forces dir<=1.
  - Leaving 11 does not clear done; done is cleared only by load or reset.
- Arithmetic is WIDTH-bit unsigned. No wrap beyond modulo is possible except in the out-of-range case above.

Decomposition:
- Package tt_counter_pkg holds the mode localparams MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PINGPONG=2'b10, MODE_ONESHOT=2'b11.
- One sub-module, tt_prescaler, parameter PRESCALE_W.
  - Inputs: clk, rst_n, en, clr (driven by load), prescale.
  - Output: tick.
- The counter FSM/datapath stays in tt_mode_counter.

Test Plan:
- WIDTH=8, mode=00, modulo=5, prescale=0, en=1 from reset -> count 0,1,2,3,4,5,0,1. tc high exactly in the cycle count shows 0 after 5.
- mode=00, prescale=2, modulo=255 -> count increments every 3rd cycle. en low for 4 cycles mid-run freezes count and prescaler; resuming gives the same 3-cycle spacing.
- mode=10, modulo=3 -> count 0,1,2,3,2,1,0,1; dir falls at 3→2 and rises at 0→1; tc asserted at both reversals.
- mode=11, modulo=4 -> count reaches 4, tc one cycle, done=1, count holds 4 for 10 ticks. load with load_val=1 -> count=1, done=0, counting resumes.
- load_val=200, modulo=50, load=1 together with a tick -> count=50 (clamped), no step that cycle. Then modulo lowered to 10 in mode 01 -> next tick count=10, tc=0.
- cmp_val=3, mode=00, modulo=7 -> match high only while count==3. rst_n low mid-count -> next cycle count=0, tc=0, done=0, dir=1.
